// File: rtl/sl_transmitter.sv
// sl_transmitter
// Serial-link transmitter for the two-wire SL0/SL1 link. Takes a 32-bit word
// over a valid/ready handshake and sends its low L bits MSB-first as low
// pulses: a pulse on sl0 is a 0 and a pulse on sl1 is a 1. An odd-parity
// cell follows the data. The frame ends with a stop marker (both lines low)
// and then an idle gap.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   data   in   [31:0] word to send, only data[L-1:0] is used
//   mode   in   [1:0] length select: 00=8, 01=16, 10=24, 11=32 bits
//   valid  in   data/mode valid
//   ready  out  idle, a word is accepted when valid & ready
//   sl0    out  link line 0, idle high, registered
//   sl1    out  link line 1, idle high, registered
//   busy   out  frame in progress
//   done   out  one-cycle pulse when the frame completes
//
// state | meaning
// IDLE  | lines high, waiting for a word
// BIT   | sending one bit cell of 4 phases (pulse in phase 2)
// STOP  | both lines low, stop marker
// GAP   | lines high for 2 phases before returning to IDLE
module sl_transmitter #(
    parameter int PHASE_CYCLES = 4,
    parameter int STOP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic [1:0]  mode,
    input  logic        valid,
    output logic        ready,
    output logic        sl0,
    output logic        sl1,
    output logic        busy,
    output logic        done
);

    localparam int CNT_MAX = (STOP_CYCLES > 2 * PHASE_CYCLES) ? STOP_CYCLES : 2 * PHASE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] P_LD = CW'(PHASE_CYCLES - 1);
    localparam logic [CW-1:0] S_LD = CW'(STOP_CYCLES - 1);
    localparam logic [CW-1:0] G_LD = CW'(2 * PHASE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, BIT, STOP, GAP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    phase, phase_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [5:0]    bit_idx, bit_idx_nxt;
    logic [31:0]   shreg, shreg_nxt;
    logic          parity, parity_nxt;
    logic          ready_nxt, sl0_nxt, sl1_nxt, busy_nxt, done_nxt;

    logic [31:0]   data_al;
    logic [5:0]    len;
    logic          cur_bit;
    logic          pulse;

    // Left-align the selected bits so the MSB of every length sits at bit 31;
    // the unused low bits are zero and do not disturb the parity.
    always_comb begin
        data_al = 32'h0;
        len     = 6'd32;
        case (mode)
            2'b00:   begin data_al = {data[7:0],  24'h0}; len = 6'd8;  end
            2'b01:   begin data_al = {data[15:0], 16'h0}; len = 6'd16; end
            2'b10:   begin data_al = {data[23:0],  8'h0}; len = 6'd24; end
            default: begin data_al = data;                len = 6'd32; end
        endcase
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        parity_nxt  = parity;

        case (state)
            IDLE: begin
                if (valid && ready) begin
                    state_nxt   = BIT;
                    phase_nxt   = 2'd0;
                    cnt_nxt     = P_LD;
                    bit_idx_nxt = len;
                    shreg_nxt   = data_al;
                    parity_nxt  = ~^data_al;
                end
            end
            BIT: begin
                if (cnt == '0) begin
                    cnt_nxt   = P_LD;
                    phase_nxt = phase + 2'd1;
                    if (phase == 2'd3) begin
                        // bit_idx counts data cells L..1, then 0 is parity
                        if (bit_idx == 6'd0) begin
                            state_nxt = STOP;
                            cnt_nxt   = S_LD;
                        end else begin
                            bit_idx_nxt = bit_idx - 6'd1;
                            shreg_nxt   = {shreg[30:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = G_LD;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            GAP: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - ONE;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so the line flops change
        // on the same edge as the state register.
        cur_bit   = (bit_idx_nxt == 6'd0) ? parity_nxt : shreg_nxt[31];
        pulse     = (state_nxt == BIT) && (phase_nxt == 2'd2);
        sl0_nxt   = (state_nxt != STOP) && !(pulse && !cur_bit);
        sl1_nxt   = (state_nxt != STOP) && !(pulse && cur_bit);
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state == GAP) && (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= 2'd0;
            cnt     <= '0;
            bit_idx <= 6'd0;
            shreg   <= 32'h0;
            parity  <= 1'b0;
            ready   <= 1'b0;
            sl0     <= 1'b1;
            sl1     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            parity  <= parity_nxt;
            ready   <= ready_nxt;
            sl0     <= sl0_nxt;
            sl1     <= sl1_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: doc/sl_transmitter.md
Name: sl_transmitter

Overview:
- Serial-link transmitter; the counterpart of the SL receiver. Drives the two-wire SL0/SL1 link.
- Accepts a 32-bit word over a valid/ready handshake, together with a 2-bit length mode.
- Serialises the word MSB-first as low pulses: SL0 pulse = 0, SL1 pulse = 1.
- Appends an odd-parity bit and a both-lines-low stop marker.
- Sits between the APB-side register block and the physical SL lines.

Parameters:
- PHASE_CYCLES, 4: clocks per bit-cell phase; each bit cell is 4 phases. Must be ≥1.
- STOP_CYCLES, 4: clocks both lines are held low for the stop marker. Must be ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- data  input  32  word to send; only the low L bits are used
- mode  input  2  length select: 00=8, 01=16, 10=24, 11=32 data bits (L)
- valid  input  1  data/mode valid
- ready  output  1  transmitter idle, accepts a word
- sl0  output  1  link line 0, idle high, registered
- sl1  output  1  link line 1, idle high, registered
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (one clock, reset=1):
  - sl0=1, sl1=1, ready=0, busy=0, done=0; state IDLE.
  - ready rises the first clock after reset deasserts.
- Handshake:
  - Word accepted on the clock edge where valid&ready=1. That edge is cycle 0.
  - data[L-1:0] and mode are latched at acceptance. Later input changes are ignored.
  - ready=0 and busy=1 from cycle 1 until the frame ends.
  - valid while busy is ignored; nothing is queued.
- Parity: p = ~^data[L-1:0], so the total count of ones over the L data bits plus p is odd.
- Frame: L data bits MSB-first, then p, giving L+1 bit cells. Then STOP, then GAP.
- States and transitions:
  - IDLE: sl0=sl1=1, ready=1. Goes to BIT on acceptance.
  - BIT: one bit cell = 4 phases of PHASE_CYCLES clocks each.
    - Phases 0 and 1: both lines high.
    - Phase 2: sl0=0 if the bit is 0, sl1=0 if the bit is 1; the other line stays high.
    - Phase 3: both lines high.
    - After the parity cell completes, go to STOP.
  - STOP: sl0=sl1=0 for STOP_CYCLES clocks, then GAP.
  - GAP: both lines high for 2*PHASE_CYCLES clocks, then IDLE.
- Cycle timing (P=PHASE_CYCLES, S=STOP_CYCLES):
  - Bit cells occupy cycles 1..(L+1)*4P.
  - Cell k (k=0 first) pulse-low window: cycles 4Pk+2P+1 .. 4Pk+3P.
  - STOP: next S cycles.
  - GAP: next 2P cycles.
  - At cycle T=(L+1)*4P+S+2P+1: ready=1, done=1 for exactly one cycle, busy=0.
  - A new word may be accepted at cycle T itself (back-to-back).
- Lines are never both low except during STOP. No glitches: outputs come straight from flops.
- Counters:
  - Phase counter sized for max(P, S, 2P).
  - Bit index counts L down to 0 (6 bits); mode decoded to L at acceptance.
- Reset mid-frame: next cycle is the reset state (lines high, ready=0). No stop marker is emitted, and the partial frame is abandoned.
- No back-pressure from the link. Transmission is open-loop.

Test Plan:
- Basic 16-bit frame: mode=01, data=32'h0000_A5A5, P=4, S=4.
  - Pulse sequence sl1,sl0,sl1,sl0, sl0,sl1,sl0,sl1, sl1,sl0,sl1,sl0, sl0,sl1,sl0,sl1, then parity sl1.
  - First pulse low during cycles 9–12; both lines low during cycles 273–276.
  - done=1 and ready=1 at cycle 285.
- Ignored upper bits: mode=00, data=32'hFFFF_FF00 -> eight sl0 pulses then parity sl1 pulse; done at cycle 157.
- 32-bit frame: mode=11, data=32'hFFFF_FFFF -> 32 sl1 pulses, then parity 1 (sl1); done at cycle 541.
- 24-bit frame: mode=10, data=32'h0000_0001 -> 23 sl0 pulses, then one sl1, then parity 0 (sl0).
- Back-to-back and busy handling:
  - valid held high with two words -> second accepted exactly at the first word's done cycle.
  - valid pulsed while busy -> no effect on the frame in progress.
- Reset mid-frame: assert reset at cycle 100 of a mode=01 frame -> sl0=sl1=1 and ready=0 next cycle; ready=1 the cycle after release; no STOP pattern is observed.
